fp_decoder: RTL and testbench

Converts a packed floating-point code (sign, 3-bit exponent, 4-bit significand) back to a 12-bit two's-complement linear value, where V = (-1)^S × F × 2^E. It is the inverse of the linear-to-float conversion path (encoder plus rounder) and sits on the expansion side of the converter. It uses an iterative one-bit-per-cycle shifter with valid/ready handshakes on both sides and accepts one conversion at a time.

---
 rtl/fp_decoder.sv | 134 +++++++++++++
 tb/tb_fp_decoder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_decoder.sv
// ---------------------------------------------------------------------------
// fp_decoder
//   Expands a packed floating-point code {S, E[2:0], F[3:0]} into a 12-bit
//   two's-complement linear value V = (-1)^S * F * 2^E.
//   An iterative shifter moves the significand left by one bit per cycle,
//   E cycles in total, so a conversion takes E+1 cycles from accept to result.
//   Only one conversion is in flight at a time.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   in_valid_i   input code present
//   in_ready_o   block can accept a code (high only while idle)
//   in_sign_i    sign bit S (1 = negative)
//   in_exp_i     exponent E, 0..7
//   in_sig_i     significand F, 0..15
//   out_valid_o  out_d_o holds a result
//   out_ready_i  consumer accepts the result
//   out_d_o      two's-complement result, range -1920..+1920
// ---------------------------------------------------------------------------
module fp_decoder (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        in_sign_i,
  input  logic [2:0]  in_exp_i,
  input  logic [3:0]  in_sig_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [11:0] out_d_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [10:0] mag_q, mag_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        sgn_q, sgn_d;
  logic        out_valid_q, out_valid_d;
  logic [11:0] out_d_q, out_d_d;

  // Apply the sign to an 11-bit magnitude. A zero magnitude always yields
  // +0 so that no negative-zero code can appear on the output.
  function automatic logic [11:0] apply_sign(input logic sgn, input logic [10:0] mag);
    logic [11:0] ext;
    ext = {1'b0, mag};
    if (mag == 11'd0) begin
      apply_sign = 12'h000;
    end else if (sgn) begin
      apply_sign = ~ext + 12'd1;
    end else begin
      apply_sign = ext;
    end
  endfunction

  // Next-state and datapath decode for the accept / shift / hold sequence.
  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    cnt_d       = cnt_q;
    sgn_d       = sgn_q;
    out_valid_d = out_valid_q;
    out_d_d     = out_d_q;

    case (state_q)
      ST_IDLE: begin
        out_valid_d = 1'b0;
        if (in_valid_i) begin
          mag_d   = {7'b0, in_sig_i};
          cnt_d   = in_exp_i;
          sgn_d   = in_sign_i;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        if (cnt_q != 3'd0) begin
          mag_d = {mag_q[9:0], 1'b0};
          cnt_d = cnt_q - 3'd1;
        end else begin
          out_d_d     = apply_sign(sgn_q, mag_q);
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        // out_d_q is left untouched on transfer; it keeps the last result.
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      mag_q       <= 11'd0;
      cnt_q       <= 3'd0;
      sgn_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_d_q     <= 12'h000;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      cnt_q       <= cnt_d;
      sgn_q       <= sgn_d;
      out_valid_q <= out_valid_d;
      out_d_q     <= out_d_d;
    end
  end

  assign in_ready_o  = (state_q == ST_IDLE);
  assign out_valid_o = out_valid_q;
  assign out_d_o     = out_d_q;

endmodule

// File: tb/tb_fp_decoder.sv
module tb_fp_decoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [2:0]  in_exp;
  logic [3:0]  in_sig;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_d;

  logic ordy_ctl;
  logic rnd_mode;
  logic rnd_bit;
  assign out_ready = rnd_mode ? rnd_bit : ordy_ctl;

  int checks;
  int errors;
  int cyc;

  typedef struct {
    int value;
    int lat;
    int acc;
  } exp_t;
  exp_t exp_q[$];

  fp_decoder dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_sign_i  (in_sign),
    .in_exp_i   (in_exp),
    .in_sig_i   (in_sig),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_d_o    (out_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Random consumer backpressure, changed well clear of both clock edges.
  always @(posedge clk) begin
    #2;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  // Reference model: signed value straight from V = (-1)^S * F * 2^E.
  function automatic int model(input bit s, input int e, input int f);
    int mag;
    mag = f * (1 << e);
    return s ? -mag : mag;
  endfunction

  // Monitor / scoreboard.
  bit          prev_v;
  logic [11:0] prev_d;
  bit          chk_after;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v    = 1'b0;
      chk_after = 1'b0;
    end else begin
      if (chk_after) begin
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
          errors++;
          $display("FAIL after_xfer: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        chk_after = 1'b0;
      end
      if (out_valid === 1'b1) begin
        if (!prev_v) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: out_d=%h with no pending code", out_d);
          end else if (cyc - exp_q[0].acc != exp_q[0].lat) begin
            errors++;
            $display("FAIL latency: got %0d cycles, required %0d", cyc - exp_q[0].acc, exp_q[0].lat);
          end
        end else begin
          checks++;
          if (out_d !== prev_d) begin
            errors++;
            $display("FAIL hold: out_d=%h changed, required %h", out_d, prev_d);
          end
        end
        if (out_ready === 1'b1 && exp_q.size() != 0) begin
          checks++;
          if ($signed(out_d) != exp_q[0].value) begin
            errors++;
            $display("FAIL out_d: got %0d (%h), required %0d", $signed(out_d), out_d, exp_q[0].value);
          end
          void'(exp_q.pop_front());
          chk_after = 1'b1;
        end
      end
      prev_v = (out_valid === 1'b1) && (out_ready !== 1'b1);
      prev_d = out_d;
    end
  end

  task automatic send(input bit s, input int e, input int f);
    int guard;
    exp_t x;
    guard = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 200) begin
      errors++;
      $display("FAIL in_ready_timeout: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = 3'(e);
    in_sig   = 4'(f);
    @(posedge clk);
    #1;
    x.value = model(s, e, f);
    x.lat   = e + 1;
    x.acc   = cyc;
    exp_q.push_back(x);
    in_valid = 1'b0;
    in_sign  = 1'($urandom);
    in_exp   = 3'($urandom);
    in_sig   = 4'($urandom);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || out_valid === 1'b1) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 500) begin
      errors++;
      $display("FAIL drain_timeout: %0d results pending, required 0", exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_d !== 12'h000) begin
      errors++;
      $display("FAIL %s: in_ready=%b out_valid=%b out_d=%h required 1/0/000",
               name, in_ready, out_valid, out_d);
    end
  endtask

  initial begin
    int guard;
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sign  = 1'b0;
    in_exp   = 3'd0;
    in_sig   = 4'd0;
    ordy_ctl = 1'b1;
    rnd_mode = 1'b0;
    rnd_bit  = 1'b1;

    #12;
    check_idle("reset_hold");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset_release");

    // Directed codes from the plan.
    send(1'b0, 0, 5);
    send(1'b0, 7, 15);
    send(1'b1, 7, 15);
    send(1'b1, 3, 0);
    send(1'b1, 2, 9);
    drain();

    // Backpressure with ignored input pulses.
    ordy_ctl = 1'b0;
    send(1'b0, 4, 3);
    guard = 0;
    while (out_valid !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 50) begin
      errors++;
      $display("FAIL bp_valid_timeout: out_valid=%b required 1", out_valid);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_d !== 12'h030) begin
        errors++;
        $display("FAIL bp_hold: in_ready=%b out_d=%h required 0/030", in_ready, out_d);
      end
      in_valid = i[0];
      in_sign  = 1'($urandom);
      in_exp   = 3'($urandom);
      in_sig   = 4'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    ordy_ctl = 1'b1;
    drain();

    // Asynchronous reset in the middle of a long conversion.
    send(1'b0, 6, 7);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    exp_q.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    send(1'b0, 1, 1);
    drain();

    // Back-to-back sweep of every code.
    for (int c = 0; c < 256; c++) begin
      send(c[7], int'(c[6:4]), int'(c[3:0]));
    end
    drain();

    // Random codes under random backpressure.
    rnd_mode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
    end
    drain();
    rnd_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
